// File: rtl/dapa_pkg.sv
// Shared definitions for the DAPA2014 datapath: opcodes, sequencer states
// and the default data width.
package dapa_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_STORE = 2'b01,
      OP_ADD   = 2'b10,
      OP_SUB   = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RD_AC  = 2'b01,
      S_RD_SRC = 2'b10,
      S_WR     = 2'b11
   } state_t;

endpackage

// File: rtl/ac_seq_addsub.sv
// Combinational WIDTH-bit adder/subtractor. carry is the carry-out for an
// add and the borrow (a < b) for a subtract.
module addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic [WIDTH:0] ext;

   // Widen by one bit so the top bit is carry (add) or borrow (subtract).
   always_comb begin
      ext = '0;
      if (sub) ext = {1'b0, a} - {1'b0, b};
      else     ext = {1'b0, a} + {1'b0, b};
      result = ext[WIDTH-1:0];
      carry  = ext[WIDTH];
   end

endmodule

// File: rtl/ac_seq.sv
// Accumulator transfer sequencer. Each accepted command walks
// IDLE -> (RD_AC) -> (RD_SRC) -> WR -> IDLE. All strobes and data outputs
// are registered alongside the state, so each strobe is high for exactly the
// cycle its state occupies. bus_in is sampled at the edge that closes a read
// cycle.
//
// Handshake: start is accepted only on an edge where busy=0; busy is 0 in
// the done cycle, so a start there is taken immediately.
module ac_seq
   import dapa_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] bus_in,
   output logic             rac,
   output logic             src_re,
   output logic             wac,
   output logic [WIDTH-1:0] ac_wdata,
   output logic             dst_we,
   output logic [WIDTH-1:0] dst_wdata,
   output logic             busy,
   output logic             done,
   output logic             flag_c,
   output logic             flag_z
);

   state_t          state;
   op_t             op_q;
   logic [WIDTH-1:0] hold_a;
   logic [WIDTH-1:0] hold_b;
   logic             res_c;
   logic [WIDTH-1:0] as_result;
   logic             as_carry;

   // The second operand comes straight off the bus in RD_SRC so the result
   // is ready to register on the edge that enters WR.
   addsub #(.WIDTH(WIDTH)) u_addsub (
      .a      (hold_a),
      .b      (bus_in),
      .sub    (op_q == OP_SUB),
      .result (as_result),
      .carry  (as_carry)
   );

   // Sequencer: state, registered strobes, holding registers and flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         op_q      <= OP_LOAD;
         rac       <= 1'b0;
         src_re    <= 1'b0;
         wac       <= 1'b0;
         dst_we    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hold_a    <= '0;
         hold_b    <= '0;
         res_c     <= 1'b0;
         ac_wdata  <= '0;
         dst_wdata <= '0;
         flag_c    <= 1'b0;
         flag_z    <= 1'b0;
      end else begin
         rac    <= 1'b0;
         src_re <= 1'b0;
         wac    <= 1'b0;
         dst_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q <= op_t'(op);
                  busy <= 1'b1;
                  if (op_t'(op) == OP_LOAD) begin
                     state  <= S_RD_SRC;
                     src_re <= 1'b1;
                  end else begin
                     state <= S_RD_AC;
                     rac   <= 1'b1;
                  end
               end
            end
            S_RD_AC: begin
               hold_a <= bus_in;
               if (op_q == OP_STORE) begin
                  state     <= S_WR;
                  dst_we    <= 1'b1;
                  dst_wdata <= bus_in;
               end else begin
                  state  <= S_RD_SRC;
                  src_re <= 1'b1;
               end
            end
            S_RD_SRC: begin
               hold_b <= bus_in;
               state  <= S_WR;
               wac    <= 1'b1;
               if (op_q == OP_LOAD) begin
                  ac_wdata <= bus_in;
               end else begin
                  ac_wdata <= as_result;
                  res_c    <= as_carry;
               end
            end
            S_WR: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
               case (op_q)
                  OP_LOAD: flag_z <= (hold_b == '0);
                  OP_ADD,
                  OP_SUB: begin
                     flag_c <= res_c;
                     flag_z <= (ac_wdata == '0);
                  end
                  default: ;
               endcase
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ac_seq.sv
// Bench for ac_seq: directed commands with hand-computed results pushed into
// an expected queue; a negedge monitor checks write strobes and done pulses
// against the queue head, including cycle-exact timing.
module tb_ac_seq;

   logic       clk;
   logic       reset;
   logic       start;
   logic [1:0] op;
   logic [7:0] bus_in;
   logic       rac, src_re, wac, dst_we, busy, done, flag_c, flag_z;
   logic [7:0] ac_wdata, dst_wdata;

   logic [7:0] acc_val;
   logic [7:0] src_val;

   typedef struct {
      logic       kind;      // 0: accumulator write, 1: destination write
      logic [7:0] data;
      logic       c;
      logic       z;
      int         wr_cyc;
      int         done_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;
   bit   wr_seen = 0;

   ac_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .bus_in    (bus_in),
      .rac       (rac),
      .src_re    (src_re),
      .wac       (wac),
      .ac_wdata  (ac_wdata),
      .dst_we    (dst_we),
      .dst_wdata (dst_wdata),
      .busy      (busy),
      .done      (done),
      .flag_c    (flag_c),
      .flag_z    (flag_z)
   );

   // Bus model: accumulator or source register drives when enabled.
   assign bus_in = rac ? acc_val : (src_re ? src_val : 8'hEE);

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Driver: called at a negedge; returns at the negedge of the done cycle.
   task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] s,
                        input logic [7:0] d, input logic c, input logic z, input bit hold);
      int   n;
      int   lat;
      exp_t e;
      lat = (o[1]) ? 4 : 3;
      n   = cyc;
      e.kind = (o == 2'b01);
      e.data = d;
      e.c = c;
      e.z = z;
      e.wr_cyc = n + lat - 1;
      e.done_cyc = n + lat;
      exp_q.push_back(e);
      start = 1'b1;
      op = o;
      acc_val = a;
      src_val = s;
      do begin
         @(negedge clk);
         if (!hold || cyc == n + lat) start = 1'b0;
      end while (cyc != n + lat);
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (rac && src_re) chk("rac_src_exclusive", 1, 0);
      if ($countones({rac, src_re, wac, dst_we}) > 1) chk("one_strobe", 1, 0);
      if (wac || dst_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {wac, dst_we}, 0);
         end else begin
            chk("write_kind", dst_we, exp_q[0].kind);
            chk("write_once", wr_seen, 0);
            chk("write_data", dst_we ? dst_wdata : ac_wdata, exp_q[0].data);
            chk("write_cycle", cyc, exp_q[0].wr_cyc);
            chk("busy_in_wr", busy, 1);
            wr_seen = 1;
         end
      end
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", done, 0);
         end else begin
            chk("done_after_write", wr_seen, 1);
            chk("done_cycle", cyc, exp_q[0].done_cyc);
            chk("flag_c", flag_c, exp_q[0].c);
            chk("flag_z", flag_z, exp_q[0].z);
            chk("busy_in_done", busy, 0);
            void'(exp_q.pop_front());
            wr_seen = 0;
         end
      end
   end

   // Stimulus
   initial begin
      int n;
      reset = 1'b0;
      start = 1'b1;
      op = 2'b10;
      acc_val = 8'h00;
      src_val = 8'h00;
      repeat (2) begin
         @(negedge clk);
         chk("reset_ctrl", {rac, src_re, wac, dst_we, busy, done, flag_c, flag_z}, 0);
         chk("reset_data", {ac_wdata, dst_wdata}, 0);
      end
      start = 1'b0;
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_after_reset", {rac, src_re, wac, dst_we, busy, done}, 0);
      end

      // LOAD 0x5A, then LOAD 0x00
      issue(2'b00, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 0);
      @(negedge clk);
      issue(2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 0);
      @(negedge clk);
      // STORE 0x3C: flags unchanged
      issue(2'b01, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b1, 0);
      @(negedge clk);
      // ADD with carry out
      issue(2'b10, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 0);
      @(negedge clk);
      // SUB to zero
      issue(2'b11, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 0);
      @(negedge clk);
      // SUB with borrow
      issue(2'b11, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 0);
      @(negedge clk);
      // start held high throughout a LOAD: only one command
      issue(2'b00, 8'h00, 8'h80, 8'h80, 1'b1, 1'b0, 1);
      @(negedge clk);
      // back-to-back: LOAD, STORE and ADD each issued in the previous done cycle
      issue(2'b00, 8'h00, 8'h01, 8'h01, 1'b1, 1'b0, 0);
      issue(2'b01, 8'h77, 8'h00, 8'h77, 1'b1, 1'b0, 0);
      issue(2'b10, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1, 0);
      @(negedge clk);
      chk("idle_after_chain", busy, 0);

      // reset in the RD_SRC cycle of an ADD
      n = cyc;
      start = 1'b1;
      op = 2'b10;
      acc_val = 8'h11;
      src_val = 8'h22;
      @(negedge clk);
      start = 1'b0;
      chk("abort_rd_ac", rac, 1);
      @(negedge clk);
      chk("abort_rd_src", src_re, 1);
      chk("abort_timing", cyc, n + 2);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_ctrl", {rac, src_re, wac, dst_we, busy, done, flag_c, flag_z}, 0);
      chk("abort_data", {ac_wdata, dst_wdata}, 0);
      reset = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("abort_quiet", {wac, busy, done}, 0);
      end

      // after reset the carry is clear; LOAD 0x00 sets zero only
      issue(2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 0);
      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ac_seq.md
# ac_seq

Transfer sequencer that drives the accumulator from the other side of its interface. It generates the `wac` and `rac` strobes, samples the shared 8-bit data bus, and moves operands between the accumulator and a source or destination register. It sits between the control unit and the accumulator/register bus of the DAPA2014 datapath. It executes one of LOAD, STORE, ADD or SUB per `start` command and returns a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 8: data width of the bus, the accumulator and the holding registers.
- `clk` input 1: single clock; every transition is on the rising edge.
- `reset` input 1: synchronous, active-low.
- `start` input 1: command strobe; sampled only while `busy`=0.
- `op` input 2: 00 LOAD, 01 STORE, 10 ADD, 11 SUB; sampled with `start`.
- `bus_in` input WIDTH: shared tri-state data bus, driven by the accumulator (`rac`) or the source register (`src_re`).
- `rac` output 1: accumulator read enable.
- `src_re` output 1: source register read enable.
- `wac` output 1: accumulator write enable.
- `ac_wdata` output WIDTH: value presented to the accumulator input, valid while `wac`=1.
- `dst_we` output 1: destination register write enable.
- `dst_wdata` output WIDTH: value for the destination, valid while `dst_we`=1.
- `busy` output 1: a command is in progress.
- `done` output 1: one-cycle completion pulse.
- `flag_c`, `flag_z` output 1 each: carry/borrow flag and zero flag, both registered.

## Operation
- States are IDLE, RD_AC, RD_SRC and WR. `busy` = (state ≠ IDLE).
- Command acceptance happens in IDLE with `start`=1. On that edge, `op` is latched into `op_q` and the next state is set:
  - LOAD → RD_SRC.
  - STORE, ADD and SUB → RD_AC.
- RD_AC:
  - `rac`=1; `bus_in` is captured into `hold_a` at the end of the cycle.
  - Next state is WR for STORE and RD_SRC for ADD/SUB.
- RD_SRC:
  - `src_re`=1; `bus_in` is captured into `hold_b`.
  - Next state is WR.
- WR: exactly one write strobe for one cycle, then return to IDLE.
  - LOAD: `wac`=1, `ac_wdata`=`hold_b`. `flag_z` ← (`hold_b`==0); `flag_c` is unchanged.
  - STORE: `dst_we`=1, `dst_wdata`=`hold_a`. Both flags are unchanged.
  - ADD: `wac`=1. `{c,r}` = `hold_a`+`hold_b` computed at WIDTH+1 bits; `ac_wdata`=r, `flag_c`←c, `flag_z`←(r==0).
  - SUB: `wac`=1, `ac_wdata`=`hold_a`−`hold_b` mod 2^WIDTH. `flag_c`←(`hold_a`<`hold_b`), i.e. borrow; `flag_z`←(result==0).
- `done` is registered. It is 1 in the cycle immediately after WR, and is otherwise 0.
- Bus exclusivity:
  - `rac` and `src_re` are never 1 in the same cycle.
  - No read strobe is ever asserted together with `wac`/`dst_we`.
- `start` while `busy`=1 is ignored. It is not queued, and neither `op_q` nor any state changes.
- When `wac`/`dst_we`=0, `ac_wdata`/`dst_wdata` hold their last value. They must not be relied upon.

## Timing
- Reset (`reset`=0 at an edge), in any state including mid-command:
  - state → IDLE.
  - `rac`, `src_re`, `wac`, `dst_we`, `busy`, `done` = 0.
  - `hold_a`, `hold_b`, `ac_wdata`, `dst_wdata`, `flag_c`, `flag_z` = 0.
  - No write strobe is issued for the aborted command.
- All strobes are decoded from registered state and are glitch-free for one full cycle. The bus read is asynchronous, so `bus_in` is sampled at the edge that closes the strobe cycle.
- Latency, counted from the accepting edge E to the `done` cycle:
  - LOAD: `src_re` in E+1, `wac` in E+2, `done` in E+3.
  - STORE: `rac` in E+1, `dst_we` in E+2, `done` in E+3.
  - ADD/SUB: `rac` in E+1, `src_re` in E+2, `wac` in E+3, `done` in E+4.
- Back-to-back commands: `busy`=0 in the `done` cycle, so a `start` in that cycle is accepted. The sustained rate is one command per 3 cycles (LOAD/STORE) or 4 cycles (ADD/SUB).
- Flags update on the edge that ends WR and are visible in the `done` cycle.

## Structure
- Shared package `dapa_pkg`:
  - op encodings `OP_LOAD`, `OP_STORE`, `OP_ADD`, `OP_SUB`.
  - state encoding `S_IDLE`, `S_RD_AC`, `S_RD_SRC`, `S_WR`.
  - default `WIDTH`.
- One sub-module, `addsub`: combinational WIDTH-bit add/subtract producing result and carry/borrow. Everything else (FSM, holding registers, flags) is in `ac_seq`.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `start`=1 → all outputs 0, `busy`=0; release → IDLE, no strobes.
- LOAD: `bus_in`=0x5A during `src_re`.
  - `wac` pulses exactly once with `ac_wdata`=0x5A.
  - `flag_z`=0; `done` at E+3.
  - Repeat with `bus_in`=0x00 → `flag_z`=1.
- STORE: `bus_in`=0x3C during `rac` → one `dst_we` pulse with `dst_wdata`=0x3C, flags unchanged, `done` at E+3.
- ADD with overflow: accumulator 0xF0, source 0x20 → `ac_wdata`=0x10, `flag_c`=1, `flag_z`=0, `done` at E+4.
  - SUB with 0x10−0x10 → 0x00, `flag_c`=0, `flag_z`=1.
  - SUB with 0x05−0x07 → 0xFE, `flag_c`=1.
- Protocol:
  - `start` held high during a command is ignored.
  - `start` in the `done` cycle is accepted.
  - Assert throughout that `rac`&`src_re` is never 1 and at most one strobe is high per cycle.
- Reset mid-ADD (`reset`=0 in the RD_SRC cycle) → no `wac` ever issued, next cycle IDLE with flags 0.
